smg_scan_module: RTL and testbench
==================================

SMG_SCAN_MODULE -- requirements
Module: smg_scan_module

Interface
REQ-001 The block SHALL have parameter T1MS, default 49_999, meaning the last count of one digit slot (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, meaning the de-ghost clocks at the start of each slot with all segments off.
REQ-003 The block SHALL have parameter LZ_BLANK, default 1, meaning 1 enables leading-zero suppression.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Number_Sig, input, 24 bits: six 4-bit digit codes from the BCD counter stage; [3:0] is digit 0 (least significant), [23:20] is digit 5.
REQ-007 The block SHALL have port Dot_Sig, input, 6 bits: decimal-point request per digit; bit n maps to digit n.
REQ-008 The block SHALL have port SMG_Data, output, 8 bits: segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-009 The block SHALL have port Scan_Sig, output, 6 bits: digit enables, active-low, one-cold, registered; bit n drives digit n.

Function
REQ-010 Slot counter C1 SHALL count 0..T1MS, wrap to 0 after T1MS, and advance digit index i on wrap.
REQ-011 Index i SHALL step 0,1,2,3,4,5 and return to 0 after 5.
REQ-012 On every transition of i from 5 to 0, and on the first clock after reset release, Number_Sig and Dot_Sig SHALL be copied into snapshot registers; decode SHALL use only the snapshot, so a frame never tears.
REQ-013 Scan_Sig SHALL equal ~(6'b1 << i), updated one clock after i changes.
REQ-014 While C1 < BLANK_CYCLES, SMG_Data SHALL be 8'hFF; Scan_Sig SHALL still select the current digit.
REQ-015 Otherwise SMG_Data[6:0] SHALL be the active-low 7-segment pattern of snapshot digit i.
REQ-016 Codes 0-9 SHALL decode to the decimal glyphs; codes A-F SHALL decode to hex glyphs A,b,C,d,E,F.
REQ-017 SMG_Data[7] SHALL be 0 (dp lit) exactly when snapshot dot bit i is 1 and the slot is not in the de-ghost window.
REQ-018 With LZ_BLANK=1, digit n (n=5..1) SHALL be blanked (8'hFF) when snapshot digits 5..n are all 0 and no snapshot dot bit in 5..n is set.
REQ-019 Digit 0 SHALL never be leading-zero blanked.
REQ-020 With LZ_BLANK=0, every digit SHALL be shown.
REQ-021 Latency SHALL be one clock from any change of C1 or i to the corresponding SMG_Data/Scan_Sig update.
REQ-022 A Number_Sig change mid-frame SHALL appear only from the next digit-0 slot onward.

Reset
REQ-023 While RST=1, C1, i, the snapshot registers and Dot snapshot SHALL be 0, SMG_Data SHALL be 8'hFF, and Scan_Sig SHALL be 6'h3F; this state SHALL be entered immediately, regardless of CLK.
REQ-024 After RST falls, scanning SHALL restart at digit 0 with a fresh snapshot; reset asserted mid-slot SHALL abandon that slot with no partial output.

Structure
REQ-025 A shared package smg_pkg SHALL hold the 16-entry active-low segment glyph constants, SEG_OFF = 8'hFF, and the digit count constant 6.
REQ-026 The glyph decode SHALL be one sub-module, smg_encode_module (4-bit code in, 7-bit segments out, combinational); counter, index, snapshot, blanking and output registers SHALL live in smg_scan_module.

Verification (bench sets T1MS=9, BLANK_CYCLES=2)
REQ-027 Reset test: assert RST mid-slot -> same cycle SMG_Data=8'hFF, Scan_Sig=6'h3F; release -> first enabled digit is 0 (Scan_Sig=6'h3E).
REQ-028 Scan order test: Number_Sig=24'h123456, Dot_Sig=0 -> Scan_Sig sequence 3E,3D,3B,37,2F,1F, 10 clocks each; SMG_Data shows 6,5,4,3,2,1 (6 -> 8'h82 ... 1 -> 8'hF9); first 2 clocks of each slot are 8'hFF.
REQ-029 Leading-zero test: Number_Sig=24'h000105, LZ_BLANK=1 -> digits 5,4,3 show 8'hFF, digit 2 shows 1, digit 1 shows 0 (8'hC0), digit 0 shows 5.
REQ-030 All-zero/dot test: Number_Sig=0, Dot_Sig=6'b000100 -> digits 5,4,3 blank; digit 2 shows 8'h40 (0 with dp lit); digits 1 and 0 show 8'hC0.
REQ-031 Tear test: change Number_Sig from 24'h111111 to 24'h999999 while digit 3 is active -> digits 3..5 of that frame still show 1; the next frame shows 9 (8'h90) on all digits.
REQ-032 Hex test: Number_Sig=24'hABCDEF -> digit 0 shows F (8'h8E) and digit 5 shows A (8'h88).

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants for the six-digit 7-segment scanner:
// active-low glyph table {g,f,e,d,c,b,a}, blank pattern and digit count.
package smg_pkg;

    localparam int DIGITS = 6;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [3:0] digit_t;

    // Entry n is the glyph for code n (0-9, then A,b,C,d,E,F)
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/smg_encode_module.sv
// Combinational 4-bit code to active-low 7-segment glyph decode.
module smg_encode_module
    import smg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_GLYPH[i_code];

endmodule

// File: rtl/smg_scan_module.sv
// Six-digit multiplexed display scanner with frame snapshot,
// de-ghost blanking and leading-zero suppression.
module smg_scan_module
    import smg_pkg::*;
#(
    parameter int T1MS         = 49_999,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] Number_Sig,
    input  logic [5:0]  Dot_Sig,
    output logic [7:0]  SMG_Data,
    output logic [5:0]  Scan_Sig
);

    localparam int CW = (T1MS < 1) ? 1 : $clog2(T1MS + 1);

    logic [CW-1:0]              r_c1;
    logic [2:0]                 r_idx;
    logic [DIGITS-1:0][3:0]     r_num;
    logic [DIGITS-1:0]          r_dot;
    logic                       r_first;

    logic                       w_wrap;
    logic                       w_last;
    logic                       w_load;
    logic                       w_ghost;
    logic                       w_lz;
    logic [DIGITS-1:0]          w_lead;
    digit_t                     w_digit;
    logic [6:0]                 w_seg;

    assign w_wrap  = (r_c1 == CW'(T1MS));
    assign w_last  = (r_idx == 3'(DIGITS - 1));
    assign w_load  = r_first || (w_wrap && w_last);
    assign w_ghost = (int'(r_c1) < BLANK_CYCLES);
    assign w_digit = r_num[r_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_c1    <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_wrap) begin
                r_c1  <= '0;
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_c1 <= r_c1 + 1'b1;
            end
        end
    end

    // Frame snapshot: refreshed only when digit 0 is about to start
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_num <= '0;
            r_dot <= '0;
        end else if (w_load) begin
            r_num <= Number_Sig;
            r_dot <= Dot_Sig;
        end
    end

    always_comb begin
        logic run;
        run    = 1'b1;
        w_lead = '0;
        for (int n = DIGITS - 1; n >= 1; n--) begin
            run       = run && (r_num[n] == 4'd0) && !r_dot[n];
            w_lead[n] = run;
        end
    end

    assign w_lz = (LZ_BLANK != 0) && w_lead[r_idx];

    smg_encode_module u_encode (
        .i_code (w_digit),
        .o_seg  (w_seg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SMG_Data <= SEG_OFF;
            Scan_Sig <= 6'h3F;
        end else begin
            Scan_Sig <= ~(6'd1 << r_idx);
            if (w_ghost || w_lz) begin
                SMG_Data <= SEG_OFF;
            end else begin
                SMG_Data <= {~r_dot[r_idx], w_seg};
            end
        end
    end

endmodule

// File: tb/tb_smg_scan_module.sv
// Bench for smg_scan_module: directed frames plus randomized
// stimulus against a cycle-count based display model.
module tb_smg_scan_module;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] Number_Sig = '0;
    logic [5:0]  Dot_Sig = '0;
    logic [7:0]  SMG_Data, SMG_Data_nl;
    logic [5:0]  Scan_Sig, Scan_Sig_nl;

    int n_tests = 0;
    int n_fail  = 0;

    smg_scan_module #(.T1MS(9), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
        .CLK(CLK), .RST(RST), .Number_Sig(Number_Sig), .Dot_Sig(Dot_Sig),
        .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig)
    );

    smg_scan_module #(.T1MS(9), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_nl (
        .CLK(CLK), .RST(RST), .Number_Sig(Number_Sig), .Dot_Sig(Dot_Sig),
        .SMG_Data(SMG_Data_nl), .Scan_Sig(Scan_Sig_nl)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Display seen t cycles after release: 10-cycle slots, 6 digits per frame
    function automatic logic [7:0] model_out(input logic [23:0] num,
                                             input logic [5:0] dot,
                                             input int t, input bit lz);
        int d, p;
        bit lead;
        logic [3:0] code;
        d = (t / 10) % 6;
        p = t % 10;
        code = 4'(num >> (4 * d));
        if (p < 2) return 8'hFF;
        if (lz && d > 0) begin
            lead = 1'b1;
            for (int j = 5; j >= d; j--)
                if (4'(num >> (4 * j)) != 4'd0 || dot[j]) lead = 1'b0;
            if (lead) return 8'hFF;
        end
        return {~dot[d], glyph(code)};
    endfunction

    int          m_k;
    logic [23:0] m_num;
    logic [5:0]  m_dot;
    logic [7:0]  e_data, e_data_nl;
    logic [5:0]  e_scan;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_k = 0; m_num = '0; m_dot = '0;
            e_data = 8'hFF; e_data_nl = 8'hFF; e_scan = 6'h3F;
        end else begin
            e_data    = model_out(m_num, m_dot, m_k, 1'b1);
            e_data_nl = model_out(m_num, m_dot, m_k, 1'b0);
            e_scan    = 6'h3F & ~(6'd1 << ((m_k / 10) % 6));
            m_k++;
            if (m_k == 1 || m_k % 60 == 0) begin
                m_num = Number_Sig;
                m_dot = Dot_Sig;
            end
        end
    end

    task automatic do_reset(input logic [23:0] n, input logic [5:0] d);
        @(negedge CLK);
        RST = 1'b1;
        Number_Sig = n;
        Dot_Sig = d;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(24'h123456, 6'h00);
        repeat (13) @(negedge CLK);
        n_tests++;
        if (SMG_Data !== 8'h92 || Scan_Sig !== 6'h3D) begin
            n_fail++;
            $display("FAIL pre_reset data=%h scan=%h want 92/3D", SMG_Data, Scan_Sig);
        end
        #3 RST = 1'b1;
        #1;
        n_tests++;
        if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
            n_fail++;
            $display("FAIL async_reset data=%h scan=%h want FF/3F", SMG_Data, Scan_Sig);
        end
        @(negedge CLK);
        n_tests++;
        if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
            n_fail++;
            $display("FAIL held_reset data=%h scan=%h want FF/3F", SMG_Data, Scan_Sig);
        end
        RST = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3E) begin
            n_fail++;
            $display("FAIL first_digit data=%h scan=%h want FF/3E", SMG_Data, Scan_Sig);
        end
        repeat (2) @(negedge CLK);
        n_tests++;
        if (SMG_Data !== 8'h82 || Scan_Sig !== 6'h3E) begin
            n_fail++;
            $display("FAIL first_glyph data=%h scan=%h want 82/3E", SMG_Data, Scan_Sig);
        end
    endtask

    task automatic test_scan_order();
        logic [5:0] scan_tbl [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        logic [7:0] data_tbl [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        int d, p;
        do_reset(24'h123456, 6'h00);
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            d = (k - 1) / 10;
            p = (k - 1) % 10;
            n_tests++;
            if (SMG_Data !== e_data || Scan_Sig !== e_scan) begin
                n_fail++;
                $display("FAIL scan_model k=%0d data=%h/%h scan=%h/%h",
                         k, SMG_Data, e_data, Scan_Sig, e_scan);
            end
            n_tests++;
            if (Scan_Sig !== scan_tbl[d]) begin
                n_fail++;
                $display("FAIL scan_seq k=%0d scan=%h want %h", k, Scan_Sig, scan_tbl[d]);
            end
            if (p < 2) begin
                n_tests++;
                if (SMG_Data !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL deghost k=%0d data=%h want FF", k, SMG_Data);
                end
            end else begin
                n_tests++;
                if (SMG_Data !== data_tbl[d]) begin
                    n_fail++;
                    $display("FAIL scan_glyph k=%0d data=%h want %h", k, SMG_Data, data_tbl[d]);
                end
            end
        end
    endtask

    task automatic test_glyphs();
        logic [23:0] pn [3] = '{24'h000105, 24'h000000, 24'hABCDEF};
        logic [5:0]  pd [3] = '{6'b000000, 6'b000100, 6'b000000};
        logic [7:0]  ex [3][6] = '{
            '{8'h92, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF},
            '{8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF},
            '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}};
        logic [7:0]  en [3][6] = '{
            '{8'h92, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0},
            '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0},
            '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}};
        int d;
        for (int s = 0; s < 3; s++) begin
            do_reset(pn[s], pd[s]);
            for (int k = 1; k <= 60; k++) begin
                @(negedge CLK);
                d = (k - 1) / 10;
                n_tests++;
                if (SMG_Data !== e_data || SMG_Data_nl !== e_data_nl) begin
                    n_fail++;
                    $display("FAIL glyph_model set=%0d k=%0d data=%h/%h nl=%h/%h",
                             s, k, SMG_Data, e_data, SMG_Data_nl, e_data_nl);
                end
                if ((k - 1) % 10 == 5) begin
                    n_tests++;
                    if (SMG_Data !== ex[s][d] || SMG_Data_nl !== en[s][d]) begin
                        n_fail++;
                        $display("FAIL glyph set=%0d digit=%0d data=%h want %h nl=%h want %h",
                                 s, d, SMG_Data, ex[s][d], SMG_Data_nl, en[s][d]);
                    end
                end
            end
        end
    endtask

    task automatic test_tear();
        int d, p;
        logic [7:0] want;
        do_reset(24'h111111, 6'h00);
        for (int k = 1; k <= 120; k++) begin
            @(negedge CLK);
            d = ((k - 1) / 10) % 6;
            p = (k - 1) % 10;
            n_tests++;
            if (SMG_Data !== e_data || Scan_Sig !== e_scan) begin
                n_fail++;
                $display("FAIL tear_model k=%0d data=%h/%h scan=%h/%h",
                         k, SMG_Data, e_data, Scan_Sig, e_scan);
            end
            if (p == 5 && (k > 60 || d >= 3)) begin
                want = (k > 60) ? 8'h90 : 8'hF9;
                n_tests++;
                if (SMG_Data !== want) begin
                    n_fail++;
                    $display("FAIL tear k=%0d digit=%0d data=%h want %h", k, d, SMG_Data, want);
                end
            end
            if (k == 35) Number_Sig = 24'h999999;
        end
    endtask

    function automatic logic [23:0] rand_num();
        logic [23:0] n;
        n = '0;
        for (int j = 0; j < 6; j++)
            if ($urandom_range(1, 0) == 1) n = n | (24'($urandom_range(15, 0)) << (4 * j));
        return n;
    endfunction

    task automatic test_random();
        do_reset(rand_num(), 6'($urandom & $urandom & $urandom));
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            n_tests++;
            if (SMG_Data !== e_data || Scan_Sig !== e_scan ||
                SMG_Data_nl !== e_data_nl || Scan_Sig_nl !== e_scan) begin
                n_fail++;
                $display("FAIL random c=%0d data=%h/%h nl=%h/%h scan=%h,%h/%h",
                         c, SMG_Data, e_data, SMG_Data_nl, e_data_nl,
                         Scan_Sig, Scan_Sig_nl, e_scan);
            end
            if ($urandom_range(24, 0) == 0) begin
                Number_Sig = rand_num();
                Dot_Sig = 6'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(299, 0) == 0) begin
                #3 RST = 1'b1;
                #1;
                n_tests++;
                if (SMG_Data !== 8'hFF || Scan_Sig !== 6'h3F) begin
                    n_fail++;
                    $display("FAIL random_reset c=%0d data=%h scan=%h want FF/3F",
                             c, SMG_Data, Scan_Sig);
                end
                @(negedge CLK);
                RST = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_glyphs();
        test_tear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
